// File: rtl/clause_sweep_ctrl.sv
// Clause store plus sequencer that sweeps every clause through re_update,
// writes results back, counts satisfied clauses and flags the first unit/conflict.
module clause_sweep_ctrl #(
    parameter int WIDTH        = 4,
    parameter int MAX_LITERALS = 8,
    parameter int NUM_CLAUSES  = 8,
    localparam int IW          = $clog2(NUM_CLAUSES),
    localparam int CW          = $clog2(NUM_CLAUSES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [IW-1:0]      load_addr,
    input  logic [3*WIDTH-1:0] load_cnf,
    input  logic [2:0]         load_mask,
    input  logic               load_active,
    input  logic               load_valid,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               conflict,
    output logic               unit_found,
    output logic [WIDTH-1:0]   unit_literal,
    output logic [IW-1:0]      unit_index,
    output logic [CW-1:0]      sat_count,
    output logic [2:0]         upd_clause,
    output logic [3*WIDTH-1:0] upd_cnf,
    output logic               upd_active,
    output logic               upd_valid,
    input  logic [2:0]         upd_clause_r,
    input  logic [3*WIDTH-1:0] upd_cnf_r,
    input  logic               upd_active_r,
    input  logic               upd_valid_r
);

    if (MAX_LITERALS > (1 << (WIDTH - 1))) begin : g_bad_width
        $error("MAX_LITERALS does not fit in the literal index field");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [3*WIDTH-1:0] r_cnf    [NUM_CLAUSES];
    logic [2:0]         r_mask   [NUM_CLAUSES];
    logic               r_active [NUM_CLAUSES];
    logic               r_valid  [NUM_CLAUSES];

    logic [IW-1:0]    r_idx;
    logic             r_conflict;
    logic             r_unit_found;
    logic [WIDTH-1:0] r_unit_literal;
    logic [IW-1:0]    r_unit_index;
    logic [CW-1:0]    r_sat_count;

    logic [IW-1:0]    w_rd_idx;
    logic             w_last;
    logic             w_conf;
    logic             w_is_unit;
    logic [WIDTH-1:0] w_unit_lit;

    assign w_rd_idx   = (r_state == S_SWEEP) ? r_idx : '0;
    assign upd_cnf    = r_cnf[w_rd_idx];
    assign upd_clause = r_mask[w_rd_idx];
    assign upd_active = r_active[w_rd_idx];
    assign upd_valid  = r_valid[w_rd_idx];

    assign w_last = (r_idx == IW'(NUM_CLAUSES - 1));
    assign w_conf = upd_valid_r && upd_active_r && (upd_clause_r == 3'b000);

    // A one-hot mask names the single unassigned literal of a unit clause.
    always_comb begin
        w_is_unit  = 1'b0;
        w_unit_lit = '0;
        case (upd_clause_r)
            3'b001: begin
                w_is_unit  = 1'b1;
                w_unit_lit = upd_cnf_r[WIDTH-1:0];
            end
            3'b010: begin
                w_is_unit  = 1'b1;
                w_unit_lit = upd_cnf_r[2*WIDTH-1:WIDTH];
            end
            3'b100: begin
                w_is_unit  = 1'b1;
                w_unit_lit = upd_cnf_r[3*WIDTH-1:2*WIDTH];
            end
            default: begin
                w_is_unit  = 1'b0;
                w_unit_lit = '0;
            end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_SWEEP;
            end
            S_SWEEP: begin
                busy = 1'b1;
                if (w_last || w_conf) w_state_nx = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLAUSES; i++) begin
                r_cnf[i]    <= '0;
                r_mask[i]   <= '0;
                r_active[i] <= 1'b0;
                r_valid[i]  <= 1'b0;
            end
        end else if (r_state == S_IDLE && load_en) begin
            r_cnf[load_addr]    <= load_cnf;
            r_mask[load_addr]   <= load_mask;
            r_active[load_addr] <= load_active;
            r_valid[load_addr]  <= load_valid;
        end else if (r_state == S_SWEEP) begin
            r_cnf[r_idx]    <= upd_cnf_r;
            r_mask[r_idx]   <= upd_clause_r;
            r_active[r_idx] <= upd_active_r;
            r_valid[r_idx]  <= upd_valid_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx          <= '0;
            r_conflict     <= 1'b0;
            r_unit_found   <= 1'b0;
            r_unit_literal <= '0;
            r_unit_index   <= '0;
            r_sat_count    <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_idx          <= '0;
            r_conflict     <= 1'b0;
            r_unit_found   <= 1'b0;
            r_unit_literal <= '0;
            r_unit_index   <= '0;
            r_sat_count    <= '0;
        end else if (r_state == S_SWEEP) begin
            if (!w_last && !w_conf) r_idx <= r_idx + 1'b1;
            if (upd_valid_r) begin
                if (!upd_active_r) begin
                    if (r_sat_count != CW'(NUM_CLAUSES))
                        r_sat_count <= r_sat_count + 1'b1;
                end else if (w_conf) begin
                    r_conflict <= 1'b1;
                end else if (w_is_unit && !r_unit_found) begin
                    r_unit_found   <= 1'b1;
                    r_unit_index   <= r_idx;
                    r_unit_literal <= w_unit_lit;
                end
            end
        end
    end

    assign conflict     = r_conflict;
    assign unit_found   = r_unit_found;
    assign unit_literal = r_unit_literal;
    assign unit_index   = r_unit_index;
    assign sat_count    = r_sat_count;

endmodule

// File: tb/tb_clause_sweep_ctrl.sv
// Bench for clause_sweep_ctrl: content-keyed re_update model plus a
// clause-store reference that predicts every sweep.
module tb_clause_sweep_ctrl;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 3;

    typedef struct packed {
        logic [3*W-1:0] cnf;
        logic [2:0]     mask;
        logic           act;
        logic           val;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_en = 1'b0;
    logic [IW-1:0]  load_addr = '0;
    logic [3*W-1:0] load_cnf = '0;
    logic [2:0]     load_mask = '0;
    logic           load_active = 1'b0;
    logic           load_valid = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, conflict, unit_found;
    logic [W-1:0]   unit_literal;
    logic [IW-1:0]  unit_index;
    logic [CW-1:0]  sat_count;
    logic [2:0]     upd_clause, upd_clause_r;
    logic [3*W-1:0] upd_cnf, upd_cnf_r;
    logic           upd_active, upd_active_r;
    logic           upd_valid, upd_valid_r;

    always #5 clk = ~clk;

    clause_sweep_ctrl #(
        .WIDTH(W),
        .MAX_LITERALS(8),
        .NUM_CLAUSES(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_cnf(load_cnf),
        .load_mask(load_mask),
        .load_active(load_active),
        .load_valid(load_valid),
        .start(start),
        .busy(busy),
        .done(done),
        .conflict(conflict),
        .unit_found(unit_found),
        .unit_literal(unit_literal),
        .unit_index(unit_index),
        .sat_count(sat_count),
        .upd_clause(upd_clause),
        .upd_cnf(upd_cnf),
        .upd_active(upd_active),
        .upd_valid(upd_valid),
        .upd_clause_r(upd_clause_r),
        .upd_cnf_r(upd_cnf_r),
        .upd_active_r(upd_active_r),
        .upd_valid_r(upd_valid_r)
    );

    int total = 0;
    int bad   = 0;

    // re_update stand-in: clauses whose literals match a key get a new
    // mask/active; everything else passes through unchanged.
    logic [3*W-1:0] t_key  [8];
    logic [2:0]     t_mask [8];
    logic           t_act  [8];
    logic           t_used [8];

    always_comb begin
        upd_cnf_r    = upd_cnf;
        upd_clause_r = upd_clause;
        upd_active_r = upd_active;
        upd_valid_r  = upd_valid;
        for (int i = 7; i >= 0; i--) begin
            if (t_used[i] && t_key[i] == upd_cnf) begin
                upd_clause_r = t_mask[i];
                upd_active_r = t_act[i];
            end
        end
    end

    ent_t mst [N];

    function automatic ent_t resp(ent_t e);
        ent_t r;
        r = e;
        for (int i = 0; i < 8; i++) begin
            if (t_used[i] && t_key[i] == e.cnf) begin
                r.mask = t_mask[i];
                r.act  = t_act[i];
                return r;
            end
        end
        return r;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            t_used[i] = 1'b0;
            t_key[i]  = '0;
            t_mask[i] = '0;
            t_act[i]  = 1'b0;
        end
    endtask

    task automatic set_resp(int i, logic [3*W-1:0] key, logic [2:0] m, logic a);
        t_used[i] = 1'b1;
        t_key[i]  = key;
        t_mask[i] = m;
        t_act[i]  = a;
    endtask

    task automatic load(int a, ent_t e);
        load_en     = 1'b1;
        load_addr   = IW'(a);
        load_cnf    = e.cnf;
        load_mask   = e.mask;
        load_active = e.act;
        load_valid  = e.val;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        mst[a]  = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        load_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) mst[i] = '0;
    endtask

    // Predict the sweep from the store model, then run it and compare
    // cycle by cycle; noise=1 hammers start and load_en while busy.
    task automatic run_sweep(string name, bit noise);
        ent_t pre [N];
        ent_t r;
        int e_sat, e_ui, endc;
        bit e_conf, e_uf, stop;
        logic [W-1:0] e_ul;
        e_sat = 0; e_ui = 0; e_conf = 0; e_uf = 0; e_ul = '0;
        endc = N + 1;
        stop = 0;
        for (int k = 0; k < N; k++) pre[k] = mst[k];
        for (int k = 0; k < N; k++) begin
            if (!stop) begin
                r = resp(mst[k]);
                mst[k] = r;
                if (r.val) begin
                    if (!r.act) begin
                        if (e_sat < N) e_sat++;
                    end else if (r.mask == 3'b000) begin
                        e_conf = 1; endc = k + 2; stop = 1;
                    end else if ($countones(r.mask) == 1 && !e_uf) begin
                        e_uf = 1;
                        e_ui = k;
                        for (int s = 0; s < 3; s++)
                            if (r.mask[s]) e_ul = r.cnf[s*W +: W];
                    end
                end
            end
        end

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= endc + 1; c++) begin
            total++;
            if (busy !== (c <= endc)) begin
                bad++;
                $display("FAIL %s busy c=%0d got=%b want=%b", name, c, busy, c <= endc);
            end
            total++;
            if (done !== (c == endc)) begin
                bad++;
                $display("FAIL %s done c=%0d got=%b want=%b", name, c, done, c == endc);
            end
            if (c <= endc - 1) begin
                total++;
                if ({upd_cnf, upd_clause, upd_active, upd_valid} !== pre[c-1]) begin
                    bad++;
                    $display("FAIL %s upd k=%0d got=%h want=%h", name, c - 1,
                             {upd_cnf, upd_clause, upd_active, upd_valid}, pre[c-1]);
                end
            end
            if (c >= endc) begin
                total++;
                if ({conflict, unit_found, unit_literal, unit_index, sat_count} !==
                    {e_conf, e_uf, e_ul, IW'(e_ui), CW'(e_sat)}) begin
                    bad++;
                    $display("FAIL %s status c=%0d got conf=%b uf=%b ul=%h ui=%0d sat=%0d want conf=%b uf=%b ul=%h ui=%0d sat=%0d",
                             name, c, conflict, unit_found, unit_literal, unit_index, sat_count,
                             e_conf, e_uf, e_ul, e_ui, e_sat);
                end
            end
            if (noise && c <= endc) begin
                start = 1'b1;
                if (c == 2) begin
                    load_en     = 1'b1;
                    load_addr   = 2'd2;
                    load_cnf    = 12'($urandom);
                    load_mask   = 3'b111;
                    load_active = 1'b1;
                    load_valid  = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            start   = 1'b0;
            load_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, done, conflict, unit_found} !== 4'b0000) begin
            bad++;
            $display("FAIL reset flags got=%b want=0000", {busy, done, conflict, unit_found});
        end
        total++;
        if (unit_literal !== '0 || unit_index !== '0) begin
            bad++;
            $display("FAIL reset unit got ul=%h ui=%0d want 0", unit_literal, unit_index);
        end
        total++;
        if (sat_count !== '0) begin
            bad++;
            $display("FAIL reset sat got=%0d want=0", sat_count);
        end
    endtask

    task automatic test_empty_sweep();
        clear_table();
        run_sweep("empty", 0);
    endtask

    task automatic load_four(logic [11:0] c1);
        load(0, '{cnf: 12'h123, mask: 3'b111, act: 1'b1, val: 1'b1});
        load(1, '{cnf: c1,      mask: 3'b111, act: 1'b1, val: 1'b1});
        load(2, '{cnf: 12'h789, mask: 3'b111, act: 1'b1, val: 1'b1});
        load(3, '{cnf: 12'hABC, mask: 3'b111, act: 1'b1, val: 1'b1});
    endtask

    task automatic setup_sat();
        clear_table();
        load_four(12'h456);
        set_resp(0, 12'h123, 3'b111, 1'b0);
        set_resp(1, 12'h456, 3'b111, 1'b1);
        set_resp(2, 12'h789, 3'b111, 1'b0);
        set_resp(3, 12'hABC, 3'b111, 1'b1);
    endtask

    task automatic test_sat_count();
        setup_sat();
        run_sweep("sat", 0);
    endtask

    task automatic test_unit();
        clear_table();
        load_four(12'h1E3);
        set_resp(0, 12'h123, 3'b111, 1'b1);
        set_resp(1, 12'h1E3, 3'b010, 1'b1);
        set_resp(2, 12'h789, 3'b011, 1'b1);
        set_resp(3, 12'hABC, 3'b100, 1'b1);
        run_sweep("unit", 0);
    endtask

    task automatic test_conflict();
        clear_table();
        load_four(12'h456);
        set_resp(0, 12'h456, 3'b000, 1'b1);
        run_sweep("conflict", 0);
        clear_table();
        load(1, '{cnf: 12'h5A5, mask: 3'b111, act: 1'b1, val: 1'b1});
        run_sweep("conflict_readback", 0);
    endtask

    task automatic test_back_to_back();
        setup_sat();
        run_sweep("b2b_noise", 1);
        run_sweep("b2b_after", 0);
    endtask

    task automatic test_reset_mid();
        setup_sat();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, conflict, sat_count} !== '0) begin
            bad++;
            $display("FAIL rst_mid abort got busy=%b done=%b conf=%b sat=%0d want 0",
                     busy, done, conflict, sat_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) mst[i] = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid idle c=%0d got busy=%b done=%b want 0 0", c, busy, done);
            end
        end
        clear_table();
        run_sweep("rst_mid_cleared", 0);
        setup_sat();
        run_sweep("rst_mid_reload", 0);
    endtask

    task automatic test_random();
        ent_t e;
        for (int it = 0; it < 10; it++) begin
            clear_table();
            for (int a = 0; a < N; a++) begin
                e.cnf  = 12'($urandom);
                e.mask = 3'($urandom_range(0, 7));
                e.act  = 1'($urandom_range(0, 1));
                e.val  = ($urandom_range(0, 3) != 0);
                load(a, e);
                if ($urandom_range(0, 3) != 0)
                    set_resp(a, e.cnf, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            run_sweep("random", 0);
            if ($urandom_range(0, 1) == 1) run_sweep("random_again", 0);
        end
    endtask

    initial begin
        clear_table();
        test_reset();
        test_empty_sweep();
        test_sat_count();
        test_unit();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
